// File: rtl/sw_pkg.sv
// Shared constants for the switch-array controller: DAC sequencer states,
// system states and pulse phases.
package sw_pkg;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] V1_2     = 4'd1;
  localparam logic [3:0] CNT_1_2  = 4'd2;
  localparam logic [3:0] V2_2     = 4'd3;
  localparam logic [3:0] CNT_2_2  = 4'd4;
  localparam logic [3:0] V_READ   = 4'd5;
  localparam logic [3:0] COMPLETE = 4'd6;
  localparam logic [3:0] V1_1     = 4'd7;
  localparam logic [3:0] V2_1     = 4'd8;
  localparam logic [3:0] CNT_1_1  = 4'd9;
  localparam logic [3:0] CNT_2_1  = 4'd10;

  localparam logic [2:0] SYS_CFG   = 3'd0;
  localparam logic [2:0] SYS_READ  = 3'd1;
  localparam logic [2:0] SYS_WRITE = 3'd2;
  localparam logic [2:0] SYS_OFF3  = 3'd3;
  localparam logic [2:0] SYS_OFF4  = 3'd4;

  localparam logic [1:0] P_HOLD = 2'd0;
  localparam logic [1:0] P_ON1  = 2'd1;
  localparam logic [1:0] P_ON2  = 2'd2;
  localparam logic [1:0] P_OFF  = 2'd3;

  // DAC states in which a channel keeps its previous target.
  function automatic logic is_dac_hold(input logic [3:0] dac);
    return (dac == CNT_1_1) || (dac == V2_1) || (dac == CNT_2_1) ||
           (dac == CNT_1_2) || (dac == V2_2) || (dac == CNT_2_2);
  endfunction

endpackage

// File: rtl/sw_tgt_cell.sv
// Single-channel combinational switch target: decides whether this channel
// should be on, given the global states, its mask bit and its source phase.
module sw_tgt_cell
  import sw_pkg::*;
(
  input  logic       key_state,
  input  logic       mask,
  input  logic [2:0] system_state,
  input  logic [3:0] dac_top_state,
  input  logic [1:0] phase,
  input  logic       want,
  output logic       tgt
);

  always_comb begin
    tgt = 1'b0;
    if (!key_state || !mask) begin
      tgt = 1'b0;
    end else if (system_state == SYS_READ) begin
      tgt = 1'b1;
    end else if (system_state == SYS_OFF3 || system_state == SYS_OFF4) begin
      tgt = 1'b0;
    end else if (system_state == SYS_WRITE) begin
      if (dac_top_state == V1_1 || dac_top_state == V1_2) begin
        case (phase)
          P_ON1, P_ON2: tgt = 1'b1;
          P_OFF:        tgt = 1'b0;
          default:      tgt = want;
        endcase
      end else if (is_dac_hold(dac_top_state)) begin
        tgt = want;
      end else begin
        tgt = 1'b0;
      end
    end else begin
      tgt = want;
    end
  end

endmodule

// File: rtl/sw_array_ctrl.sv
// N-channel switch-enable controller with per-channel mask and source select,
// plus a break-before-make dead-time interlock shared across all channels.
module sw_array_ctrl
  import sw_pkg::*;
#(
  parameter int N_CH     = 16,
  parameter int N_SRC    = 2,
  parameter int SRC_W    = 1,
  parameter int DEAD_CYC = 4,
  parameter int DEAD_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_state,
  input  logic [2:0]              system_state,
  input  logic [3:0]              dac_top_state,
  input  logic [2*N_SRC-1:0]      pulse_state,
  input  logic                    cfg_we,
  input  logic [N_CH-1:0]         cfg_mask,
  input  logic [N_CH*SRC_W-1:0]   cfg_src_sel,
  output logic [N_CH-1:0]         sw_en,
  output logic                    dead_active,
  output logic                    cfg_err
);

  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC);

  logic [N_CH-1:0]       r_mask;
  logic [N_CH*SRC_W-1:0] r_src_sel;
  logic [N_CH-1:0]       r_want;
  logic [N_CH-1:0]       r_sw_en;
  logic [DEAD_W-1:0]     r_dead_cnt;
  logic                  r_dead_active;
  logic                  r_cfg_err;

  logic [N_CH-1:0]       w_tgt;
  logic [N_CH-1:0]       w_sw_en_next;
  logic [DEAD_W-1:0]     w_dead_next;
  logic                  w_off_evt;
  logic                  w_release;
  logic                  w_cfg_ok;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SRC_W-1:0] w_sel;
      logic [1:0]       w_phase;

      assign w_sel = r_src_sel[gi*SRC_W +: SRC_W];

      // Out-of-range source indices fall back to source 0.
      always_comb begin
        w_phase = pulse_state[1:0];
        for (int s = 0; s < N_SRC; s++) begin
          if (int'(w_sel) == s) w_phase = pulse_state[2*s +: 2];
        end
      end

      sw_tgt_cell u_cell (
        .key_state     (key_state),
        .mask          (r_mask[gi]),
        .system_state  (system_state),
        .dac_top_state (dac_top_state),
        .phase         (w_phase),
        .want          (r_want[gi]),
        .tgt           (w_tgt[gi])
      );
    end
  endgenerate

  // Any channel turning off blocks every new turn-on this cycle and restarts dead time.
  assign w_off_evt    = |(r_sw_en & ~w_tgt);
  assign w_release    = !w_off_evt && (r_dead_cnt == '0);
  assign w_sw_en_next = w_tgt & (r_sw_en | {N_CH{w_release}});
  assign w_dead_next  = w_off_evt            ? DEAD_LOAD :
                        (r_dead_cnt != '0)   ? r_dead_cnt - DEAD_W'(1) : '0;
  assign w_cfg_ok     = (system_state == SYS_CFG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask        <= '1;
      r_src_sel     <= '0;
      r_want        <= '0;
      r_sw_en       <= '0;
      r_dead_cnt    <= '0;
      r_dead_active <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_want        <= w_tgt;
      r_sw_en       <= w_sw_en_next;
      r_dead_cnt    <= w_dead_next;
      r_dead_active <= (w_dead_next != '0);
      r_cfg_err     <= cfg_we && !w_cfg_ok;
      if (cfg_we && w_cfg_ok) begin
        r_mask    <= cfg_mask;
        r_src_sel <= cfg_src_sel;
      end
    end
  end

  assign sw_en       = r_sw_en;
  assign dead_active = r_dead_active;
  assign cfg_err     = r_cfg_err;

endmodule
